// File: rtl/mem_line_responder_if.sv
// mem_line_responder_if: line-granular request/response bus between the L1 cache controller and main memory.
interface mem_line_responder_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [ADDR_W-1:0] req_addr;
  logic [LINE_W-1:0] req_data;
  logic              resp_valid;
  logic              resp_ready;
  logic              resp_store;
  logic [ADDR_W-1:0] resp_addr;
  logic [LINE_W-1:0] resp_data;
  logic              resp_err;
  modport master (
    output req_valid, req_store, req_addr, req_data, resp_ready,
    input  req_ready, resp_valid, resp_store, resp_addr, resp_data, resp_err
  );
  modport slave (
    input  req_valid, req_store, req_addr, req_data, resp_ready,
    output req_ready, resp_valid, resp_store, resp_addr, resp_data, resp_err
  );
endinterface

// File: rtl/mem_line_responder.sv
// mem_line_responder: single-outstanding main-memory model with fixed request/response latency.
// Define BRISC_MEM_OOR_ERR_EN to flag (and block) accesses at or above MEM_BYTES instead of wrapping.
module mem_line_responder #(
  parameter int ADDR_W     = 32,
  parameter int LINE_W     = 128,
  parameter int MEM_BYTES  = 1 << 18,
  parameter int REQ_DELAY  = 5,
  parameter int RESP_DELAY = 5
) (
  input logic clk,
  input logic rst_n,
  mem_line_responder_if.slave bus
);
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int MEM_AW = $clog2(MEM_BYTES);
  localparam int IDX_W  = MEM_AW - OFF_W;
  localparam int LINES  = MEM_BYTES / (LINE_W / 8);
  localparam int MAX_D  = REQ_DELAY > RESP_DELAY ? REQ_DELAY : RESP_DELAY;
  localparam int CNT_W  = $clog2(MAX_D + 1);
  localparam logic [CNT_W-1:0]  REQ_CNT  = CNT_W'(REQ_DELAY - 1);
  localparam logic [CNT_W-1:0]  RESP_CNT = CNT_W'(RESP_DELAY - 1);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_W / 8 - 1);
  if (REQ_DELAY < 1 || RESP_DELAY < 1 || (MEM_BYTES & (MEM_BYTES - 1)) != 0 || LINE_W % 8 != 0) begin : g_bad_param
    $fatal(1, "mem_line_responder: invalid parameters");
  end
  typedef enum logic [1:0] {IDLE, REQ_WAIT, RESP_WAIT, RESP} state_t;
  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              store_q, oor_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] data_q;
  logic              req_ready_q, resp_valid_q, resp_store_q, resp_err_q;
  logic [ADDR_W-1:0] resp_addr_q;
  logic [LINE_W-1:0] resp_data_q;
  logic [LINE_W-1:0] mem [LINES];
  logic [ADDR_W-1:0] line_addr_d;
  logic              oor_d;
  logic [IDX_W-1:0]  idx;
  logic              access;
  assign line_addr_d = bus.req_addr & ~OFF_MASK;
`ifdef BRISC_MEM_OOR_ERR_EN
  assign oor_d = |bus.req_addr[ADDR_W-1:MEM_AW];
`else
  assign oor_d = 1'b0;
`endif
  assign idx    = addr_q[MEM_AW-1:OFF_W];
  assign access = state_q == REQ_WAIT && cnt_q == '0;
  // Storage deliberately has no reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (access && store_q && !oor_q) mem[idx] <= data_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      store_q      <= 1'b0;
      oor_q        <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_store_q <= 1'b0;
      resp_addr_q  <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.req_valid) begin
          store_q     <= bus.req_store;
          addr_q      <= line_addr_d;
          data_q      <= bus.req_data;
          oor_q       <= oor_d;
          cnt_q       <= REQ_CNT;
          req_ready_q <= 1'b0;
          state_q     <= REQ_WAIT;
        end
        REQ_WAIT: if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
        else begin
          resp_store_q <= store_q;
          resp_addr_q  <= addr_q;
          resp_data_q  <= (store_q || oor_q) ? '0 : mem[idx];
          resp_err_q   <= oor_q;
          cnt_q        <= RESP_CNT;
          state_q      <= RESP_WAIT;
        end
        RESP_WAIT: if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
        else begin
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RESP: if (bus.resp_ready) begin
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_store = resp_store_q;
  assign bus.resp_addr  = resp_addr_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_err   = resp_err_q;
endmodule

// File: tb/tb_mem_line_responder.sv
// tb_mem_line_responder: directed stimulus with a response scoreboard checked by an independent monitor.
module tb_mem_line_responder;
  localparam logic [127:0] PRE  = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] AA55 = 128'hAAAAAAAAAAAAAAAA5555555555555555;
  localparam logic [127:0] OLD  = 128'h33333333333333333333333333333333;
  localparam logic [127:0] NEW  = 128'hCCCCCCCCCCCCCCCCCCCCCCCCCCCCCCCC;
  localparam logic [127:0] ZZZ  = 128'hDEADBEEFDEADBEEFDEADBEEFDEADBEEF;
`ifdef BRISC_MEM_OOR_ERR_EN
  localparam bit OOR = 1'b1;
`else
  localparam bit OOR = 1'b0;
`endif
  typedef struct {
    logic         st;
    logic [31:0]  addr;
    logic [127:0] data;
    logic         err;
    int           acc;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   rise_edge = 0;
  int   hs_edge = 0;
  logic prev_v = 1'b0;
  exp_t sb[$];
  mem_line_responder_if bus ();
  mem_line_responder dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bus.resp_valid && !prev_v) begin
      rise_edge = cyc;
      if (sb.size() == 0) chk("unexpected_resp", 1'b1, 1'b0);
      else chk("latency", 128'(cyc - sb[0].acc), 128'd10);
    end
    if (bus.resp_valid && bus.resp_ready && sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("resp_store", bus.resp_store, e.st);
      chk("resp_addr", bus.resp_addr, e.addr);
      chk("resp_data", bus.resp_data, e.data);
      chk("resp_err", bus.resp_err, e.err);
      hs_edge = cyc + 1;
    end
    prev_v = bus.resp_valid;
  end
  task automatic issue(input logic st, input logic [31:0] addr, input logic [127:0] data,
                       input logic [127:0] edata, input logic eerr, input bit push, output int acc);
    int k = 0;
    exp_t e;
    acc = -1;
    bus.req_valid = 1'b1;
    bus.req_store = st;
    bus.req_addr  = addr;
    bus.req_data  = data;
    while (!bus.req_ready && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (!bus.req_ready) begin
      chk("accept_timeout", 1'b0, 1'b1);
      bus.req_valid = 1'b0;
      return;
    end
    e.st = st; e.addr = addr & ~32'hF; e.data = edata; e.err = eerr; e.acc = cyc + 1;
    if (push) sb.push_back(e);
    @(posedge clk); #1;
    acc = cyc;
    bus.req_valid = 1'b0;
  endtask
  task automatic drain();
    int k = 0;
    while (sb.size() > 0 && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    chk("drain", 128'(sb.size()), 128'd0);
  endtask
  task automatic wait_valid();
    int k = 0;
    while (!bus.resp_valid && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("resp_valid_timeout", bus.resp_valid, 1'b1);
  endtask
  task automatic pulse_reset(input int after);
    repeat (after) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    chk("ready_after_rst", bus.req_ready, 1'b1);
  endtask
  initial begin
    int a, b, hs_a;
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  initial begin
    int a, b, hs_a;
    bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_addr = '0; bus.req_data = '0; bus.resp_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", bus.req_ready, 1'b1);
    chk("rst_resp_valid", bus.resp_valid, 1'b0);
    chk("rst_resp_store", bus.resp_store, 1'b0);
    chk("rst_resp_addr", bus.resp_addr, 32'h0);
    chk("rst_resp_data", bus.resp_data, 128'h0);
    chk("rst_resp_err", bus.resp_err, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(1'b1, 32'h0000_1000, PRE, 128'h0, 1'b0, 1'b1, a);
    drain();
    issue(1'b0, 32'h0000_1000, 128'h0, PRE, 1'b0, 1'b1, a);
    chk("ready_drop", bus.req_ready, 1'b0);
    drain();
    issue(1'b1, 32'h0000_2010, AA55, 128'h0, 1'b0, 1'b1, a);
    issue(1'b0, 32'h0000_201C, 128'h0, AA55, 1'b0, 1'b1, a);
    drain();
    bus.resp_ready = 1'b0;
    issue(1'b0, 32'h0000_2010, 128'h0, AA55, 1'b0, 1'b1, a);
    wait_valid();
    for (int i = 0; i < 7; i++) begin
      chk("stall_valid", bus.resp_valid, 1'b1);
      chk("stall_data", bus.resp_data, AA55);
      chk("stall_ready", bus.req_ready, 1'b0);
      bus.req_valid = i[0]; bus.req_store = 1'b1; bus.req_addr = 32'h0000_2010; bus.req_data = '0;
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("idle_ready", bus.req_ready, 1'b1);
    chk("idle_valid", bus.resp_valid, 1'b0);
    drain();
    issue(1'b0, 32'h0000_2010, 128'h0, AA55, 1'b0, 1'b1, a);
    drain();
    issue(1'b1, 32'h0000_3000, OLD, 128'h0, 1'b0, 1'b1, a);
    drain();
    issue(1'b1, 32'h0000_3000, NEW, 128'h0, 1'b0, 1'b0, a);
    pulse_reset(1);
    issue(1'b0, 32'h0000_3000, 128'h0, OLD, 1'b0, 1'b1, a);
    drain();
    issue(1'b1, 32'h0000_3000, NEW, 128'h0, 1'b0, 1'b0, a);
    pulse_reset(7);
    repeat (15) begin @(posedge clk); #1; end
    issue(1'b0, 32'h0000_3000, 128'h0, NEW, 1'b0, 1'b1, a);
    drain();
    issue(1'b0, 32'h0004_1000, 128'h0, OOR ? 128'h0 : PRE, OOR, 1'b1, a);
    issue(1'b1, 32'h0004_1000, ZZZ, 128'h0, OOR, 1'b1, a);
    issue(1'b0, 32'h0000_1000, 128'h0, OOR ? PRE : ZZZ, 1'b0, 1'b1, a);
    drain();
    issue(1'b0, 32'h0000_2010, 128'h0, AA55, 1'b0, 1'b1, a);
    issue(1'b0, 32'h0000_3000, 128'h0, NEW, 1'b0, 1'b1, b);
    hs_a = hs_edge;
    chk("b2b_accept", 128'(b - hs_a), 128'd1);
    drain();
    chk("b2b_gap", 128'(rise_edge - hs_a), 128'd11);
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
